// File: rtl/sipo_chain_receiver.sv
// sipo_chain_receiver
// Far-end receiver of the display shift-register link. It behaves like an
// N_CH-stage daisy chain of WIDTH-bit latching shift registers, clocked by the
// serial clock itself. A rising edge on the latch line evaluates the frame:
// if exactly the expected number of bits arrived it is transferred to the
// parallel outputs, otherwise the frame is rejected and the sticky error
// flag is raised.
//
// Optional feature: define SIPO_PARITY_EN to append one even-parity bit per
// frame. The extra bit is checked at latch time and reported on o_parity_err.
module sipo_chain_receiver #(
   parameter int WIDTH     = 8,
   parameter int N_CH      = 2,
   parameter int MSB_FIRST = 1
) (
   input  logic                    o_serial_clk,
   input  logic                    i_reset_n,
   input  logic                    i_serial_data,
   input  logic                    i_serial_latch,
   output logic [N_CH*WIDTH-1:0]   o_parallel_data,
   output logic                    o_cascade_data,
   output logic                    o_frame_valid,
   output logic                    o_frame_err,
   output logic [7:0]              o_frame_count
`ifdef SIPO_PARITY_EN
   ,
   output logic                    o_parity_err
`endif
);

   localparam int TOTAL = N_CH * WIDTH;
`ifdef SIPO_PARITY_EN
   localparam int FL = TOTAL + 1;
`else
   localparam int FL = TOTAL;
`endif
   // One extra count value marks "more bits than a frame" and is held there.
   localparam int CW = $clog2(FL + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(FL);
   localparam logic [CW-1:0] CNT_SAT  = CW'(FL + 1);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

`ifdef SIPO_PARITY_EN
   // Even-parity accumulator step over the incoming bit stream.
   function automatic logic parity_fold(input logic acc, input logic bit_in);
      return acc ^ bit_in;
   endfunction
`endif

   // Strips the parity position (when present) from the chain contents.
   function automatic logic [TOTAL-1:0] frame_payload(input logic [FL-1:0] chain);
`ifdef SIPO_PARITY_EN
      if (MSB_FIRST != 0) begin
         return chain[FL-1:1];
      end else begin
         return chain[TOTAL-1:0];
      end
`else
      return chain;
`endif
   endfunction

   logic [FL-1:0] chain_r;
   logic [CW-1:0] cnt_r;
   logic          latch_q_r;
`ifdef SIPO_PARITY_EN
   logic          xor_r;
`endif

   logic [FL-1:0] chain_shift_s;
   logic          cascade_shift_s;
   logic [CW-1:0] cnt_inc_s;
   logic          eval_s;
   logic          len_ok_s;
   logic          par_ok_s;
   logic          accept_s;

   // Shifted chain contents and spilled bit for the configured bit order.
   always_comb begin
      chain_shift_s   = chain_r;
      cascade_shift_s = 1'b0;
      if (MSB_FIRST != 0) begin
         chain_shift_s   = {chain_r[FL-2:0], i_serial_data};
         cascade_shift_s = chain_r[FL-1];
      end else begin
         chain_shift_s   = {i_serial_data, chain_r[FL-1:1]};
         cascade_shift_s = chain_r[0];
      end
   end

   // Latch-edge detection, saturating bit count and frame acceptance decode.
   always_comb begin
      eval_s    = i_serial_latch & ~latch_q_r;
      len_ok_s  = (cnt_r == CNT_FULL);
      cnt_inc_s = cnt_r;
      if (cnt_r != CNT_SAT) begin
         cnt_inc_s = cnt_r + CNT_ONE;
      end else begin
         cnt_inc_s = cnt_r;
      end
`ifdef SIPO_PARITY_EN
      par_ok_s = ~xor_r;
`else
      par_ok_s = 1'b1;
`endif
      accept_s = len_ok_s & par_ok_s;
   end

   // Chain, counters and all registered outputs; shift, evaluate or hold.
   always_ff @(posedge o_serial_clk) begin
      if (!i_reset_n) begin
         chain_r         <= {FL{1'b0}};
         cnt_r           <= {CW{1'b0}};
         latch_q_r       <= 1'b1;
         o_parallel_data <= {TOTAL{1'b0}};
         o_cascade_data  <= 1'b0;
         o_frame_valid   <= 1'b0;
         o_frame_err     <= 1'b0;
         o_frame_count   <= 8'd0;
`ifdef SIPO_PARITY_EN
         xor_r           <= 1'b0;
         o_parity_err    <= 1'b0;
`endif
      end else begin
         latch_q_r <= i_serial_latch;
         if (!i_serial_latch) begin
            chain_r        <= chain_shift_s;
            o_cascade_data <= cascade_shift_s;
            cnt_r          <= cnt_inc_s;
            o_frame_valid  <= 1'b0;
`ifdef SIPO_PARITY_EN
            xor_r          <= parity_fold(xor_r, i_serial_data);
`endif
         end else if (eval_s) begin
            cnt_r <= {CW{1'b0}};
`ifdef SIPO_PARITY_EN
            xor_r <= 1'b0;
`endif
            if (accept_s) begin
               o_parallel_data <= frame_payload(chain_r);
               o_frame_valid   <= 1'b1;
               o_frame_err     <= 1'b0;
               o_frame_count   <= o_frame_count + 8'd1;
`ifdef SIPO_PARITY_EN
               o_parity_err    <= 1'b0;
`endif
            end else begin
               o_frame_valid <= 1'b0;
               o_frame_err   <= 1'b1;
`ifdef SIPO_PARITY_EN
               // Only a frame of the right length can be a parity failure.
               if (len_ok_s) begin
                  o_parity_err <= 1'b1;
               end else begin
                  o_parity_err <= o_parity_err;
               end
`endif
            end
         end else begin
            o_frame_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sipo_chain_receiver.sv
// Bench for sipo_chain_receiver: one MSB-first and one LSB-first instance
// receive the same serial stream; a bit-history reference model predicts
// every output after every serial clock edge.
module tb_sipo_chain_receiver;

   localparam int WIDTH = 8;
   localparam int N_CH  = 2;
   localparam int TOTAL = WIDTH * N_CH;
`ifdef SIPO_PARITY_EN
   localparam int FL  = TOTAL + 1;
   localparam bit PAR = 1'b1;
`else
   localparam int FL  = TOTAL;
   localparam bit PAR = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             sdata;
   logic             slatch;
   logic [TOTAL-1:0] pdata_m, pdata_l;
   logic             casc_m, casc_l, valid_m, valid_l, err_m, err_l;
   logic [7:0]       cnt_m, cnt_l;
`ifdef SIPO_PARITY_EN
   logic             perr_m, perr_l;
`endif

   sipo_chain_receiver #(.WIDTH(WIDTH), .N_CH(N_CH), .MSB_FIRST(1)) dut_msb (
      .o_serial_clk    (clk),
      .i_reset_n       (rst_n),
      .i_serial_data   (sdata),
      .i_serial_latch  (slatch),
      .o_parallel_data (pdata_m),
      .o_cascade_data  (casc_m),
      .o_frame_valid   (valid_m),
      .o_frame_err     (err_m),
      .o_frame_count   (cnt_m)
`ifdef SIPO_PARITY_EN
      ,
      .o_parity_err    (perr_m)
`endif
   );

   sipo_chain_receiver #(.WIDTH(WIDTH), .N_CH(N_CH), .MSB_FIRST(0)) dut_lsb (
      .o_serial_clk    (clk),
      .i_reset_n       (rst_n),
      .i_serial_data   (sdata),
      .i_serial_latch  (slatch),
      .o_parallel_data (pdata_l),
      .o_cascade_data  (casc_l),
      .o_frame_valid   (valid_l),
      .o_frame_err     (err_l),
      .o_frame_count   (cnt_l)
`ifdef SIPO_PARITY_EN
      ,
      .o_parity_err    (perr_l)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: recent bits on the wire and the frame bookkeeping.
   bit               hist[$];
   int               fbits;
   bit               prev_latch;
   logic [TOTAL-1:0] e_data_m, e_data_l;
   bit               e_casc, e_valid, e_err, e_perr;
   logic [7:0]       e_cnt;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit d, input bit l);
      bit p;
      int base;
      p = 1'b0;
      if (!r) begin
         hist.delete();
         fbits      = 0;
         prev_latch = 1'b1;
         e_data_m   = '0;
         e_data_l   = '0;
         e_casc     = 1'b0;
         e_valid    = 1'b0;
         e_err      = 1'b0;
         e_perr     = 1'b0;
         e_cnt      = 8'd0;
      end else begin
         if (!l) begin
            hist.push_back(d);
            if (hist.size() > FL + 1) void'(hist.pop_front());
            e_casc  = (hist.size() > FL) ? hist[0] : 1'b0;
            fbits   = fbits + 1;
            e_valid = 1'b0;
         end else if (!prev_latch) begin
            if (fbits == FL) begin
               base = hist.size() - FL;
               for (int i = 0; i < FL; i++) p ^= hist[base + i];
            end
            if (fbits == FL && (!PAR || !p)) begin
               base = hist.size() - FL;
               for (int i = 0; i < TOTAL; i++) begin
                  e_data_m[TOTAL-1-i] = hist[base + i];
                  e_data_l[i]         = hist[base + i];
               end
               e_valid = 1'b1;
               e_err   = 1'b0;
               e_perr  = 1'b0;
               e_cnt   = e_cnt + 8'd1;
            end else begin
               e_valid = 1'b0;
               e_err   = 1'b1;
               if (PAR && fbits == FL) e_perr = 1'b1;
            end
            fbits = 0;
         end else begin
            e_valid = 1'b0;
         end
         prev_latch = l;
      end
   endtask

   task automatic check_outputs();
      check_eq("data_msb",  32'(pdata_m), 32'(e_data_m));
      check_eq("data_lsb",  32'(pdata_l), 32'(e_data_l));
      check_eq("casc_msb",  32'(casc_m),  32'(e_casc));
      check_eq("casc_lsb",  32'(casc_l),  32'(e_casc));
      check_eq("valid_msb", 32'(valid_m), 32'(e_valid));
      check_eq("valid_lsb", 32'(valid_l), 32'(e_valid));
      check_eq("err_msb",   32'(err_m),   32'(e_err));
      check_eq("err_lsb",   32'(err_l),   32'(e_err));
      check_eq("cnt_msb",   32'(cnt_m),   32'(e_cnt));
      check_eq("cnt_lsb",   32'(cnt_l),   32'(e_cnt));
`ifdef SIPO_PARITY_EN
      check_eq("perr_msb",  32'(perr_m),  32'(e_perr));
      check_eq("perr_lsb",  32'(perr_l),  32'(e_perr));
`endif
   endtask

   // One serial clock edge with the given inputs, then model update and check.
   task automatic step(input bit r, input bit d, input bit l);
      rst_n  = r;
      sdata  = d;
      slatch = l;
      @(posedge clk);
      #1;
      model_step(r, d, l);
      check_outputs();
   endtask

   task automatic send_word(input logic [31:0] val, input int n, input bit lsb_first);
      logic [31:0] v;
      v = val;
      for (int i = 0; i < n; i++) step(1'b1, lsb_first ? v[i] : v[n-1-i], 1'b0);
   endtask

   task automatic send_frame(input logic [TOTAL-1:0] data, input bit lsb_first, input bit bad_par);
      send_word(32'(data), TOTAL, lsb_first);
      if (PAR) step(1'b1, (^data) ^ bad_par, 1'b0);
      step(1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      logic [7:0] cnt_before;
      int         kind, n, holds;
      rst_n  = 1'b0;
      sdata  = 1'b0;
      slatch = 1'b0;

      // Reset state
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check_eq("reset_count", 32'(cnt_m), 32'd0);

      // Good MSB-first frame
      send_frame(16'hA53C, 1'b0, 1'b0);
      check_eq("a53c_data", 32'(pdata_m), 32'h0000A53C);
      check_eq("a53c_valid", 32'(valid_m), 32'd1);
      check_eq("a53c_count", 32'(cnt_m), 32'd1);

      // Short frame rejected, data held
      send_word(32'h0, TOTAL - 1 + (PAR ? 1 : 0) - 1 + 1 - (PAR ? 1 : 0), 1'b0);
      step(1'b1, 1'b0, 1'b1);
      check_eq("short_err", 32'(err_m), 32'd1);
      check_eq("short_hold", 32'(pdata_m), 32'h0000A53C);
      check_eq("short_novalid", 32'(valid_m), 32'd0);

      // Recovery with 0x0001
      send_frame(16'h0001, 1'b0, 1'b0);
      check_eq("rec_data", 32'(pdata_m), 32'h00000001);
      check_eq("rec_err", 32'(err_m), 32'd0);
      check_eq("rec_count", 32'(cnt_m), 32'd2);

      // Overrun: one extra leading 1 ahead of a full frame of ones
      send_word(32'h1, 1, 1'b0);
      send_word(32'hFFFF, 16, 1'b0);
      if (PAR) send_word(32'h1, 1, 1'b0);
      check_eq("ovr_cascade", 32'(casc_m), 32'd1);
      step(1'b1, 1'b0, 1'b1);
      check_eq("ovr_err", 32'(err_m), 32'd1);

      // LSB-first frame, latch held three edges
      cnt_before = e_cnt;
      send_frame(16'hA53C, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      check_eq("lsb_data", 32'(pdata_l), 32'h0000A53C);
      check_eq("hold_count", 32'(cnt_l), 32'(cnt_before + 8'd1));

      // Reset mid-frame, latch high through reset release
      send_word($urandom, 9, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      check_eq("rel_noerr", 32'(err_m), 32'd0);
      send_frame(16'h1234, 1'b0, 1'b0);
      check_eq("after_rst_data", 32'(pdata_m), 32'h00001234);

`ifdef SIPO_PARITY_EN
      send_frame(16'hA53C, 1'b0, 1'b0);
      check_eq("par_ok_valid", 32'(valid_m), 32'd1);
      send_frame(16'h5555, 1'b0, 1'b1);
      check_eq("par_bad_perr", 32'(perr_m), 32'd1);
      check_eq("par_bad_err", 32'(err_m), 32'd1);
      check_eq("par_bad_hold", 32'(pdata_m), 32'h0000A53C);
`endif

      // Randomized frames of mixed lengths, hold lengths and occasional resets
      for (int f = 0; f < 300; f++) begin
         kind = $urandom_range(0, 9);
         case (kind)
            0, 1, 2, 3: n = FL;
            4:          n = FL - 1;
            5:          n = FL + 1;
            6:          n = 0;
            default:    n = $urandom_range(0, FL + 3);
         endcase
         for (int i = 0; i < n; i++) step(1'b1, 1'($urandom), 1'b0);
         if ($urandom_range(0, 49) == 0) step(1'b0, 1'b0, 1'($urandom));
         holds = $urandom_range(1, 3);
         for (int h = 0; h < holds; h++) step(1'b1, 1'b0, 1'b1);
      end

      // Frame counter wrap after 256 accepted frames
      step(1'b0, 1'b0, 1'b0);
      for (int f = 0; f < 256; f++) begin
         send_frame(TOTAL'($urandom), 1'b0, 1'b0);
         if (f == 254) check_eq("count_255", 32'(cnt_m), 32'd255);
      end
      check_eq("count_wrap", 32'(cnt_m), 32'd0);
      check_eq("wrap_valid", 32'(valid_l), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
